// File: rtl/vec_mem_pkg.sv
// Shared parameters, state encoding and vector type for the vector memory burst controller.
package vec_mem_pkg;

  localparam int LANES     = 16;
  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 19;
  localparam int BURST_CYC = LANES + 2;
  localparam int DATA_OFS  = 2;
  localparam int VEC_W     = LANES * DATA_W;
  localparam int CNT_W     = 5;
  localparam int LANE_W    = $clog2(LANES);

  typedef logic [VEC_W-1:0] vec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/vec_mem_burst_ctrl_lane_buffer.sv
// 16x8 lane storage. It holds either the store vector being serialised or
// the load vector being assembled; never both in the same request.
module vec_lane_buffer
  import vec_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              ld_en,
  input  vec_t              ld_vec,
  input  logic              wr_en,
  input  logic [LANE_W-1:0] wr_lane,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [LANE_W-1:0] rd_lane,
  output logic [DATA_W-1:0] rd_data,
  output vec_t              vec
);

  vec_t vec_q, vec_d;

  // Next-value select: clear wins over a whole-vector load, which wins over a lane write.
  always_comb begin
    vec_d = vec_q;
    if (clr) begin
      vec_d = '0;
    end else if (ld_en) begin
      vec_d = ld_vec;
    end else if (wr_en) begin
      vec_d[wr_lane*DATA_W +: DATA_W] = wr_data;
    end
  end

  // Storage register.
  always_ff @(posedge clk) begin
    if (rst) vec_q <= '0;
    else     vec_q <= vec_d;
  end

  assign rd_data = vec_q[rd_lane*DATA_W +: DATA_W];
  assign vec     = vec_q;

endmodule

// File: rtl/vec_mem_burst_ctrl.sv
// Vector load/store burst controller: holds one memory enable for an 18-cycle
// window, serialises store vectors into byte beats and assembles load bytes
// into a 128-bit response.
module vec_mem_burst_ctrl
  import vec_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  vec_t              req_wdata,
  output logic              resp_valid,
  output vec_t              resp_rdata,
  output logic              busy,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  vec_t              resp_rdata_q, resp_rdata_d;

  logic              buf_clr, buf_ld, buf_wr;
  logic [LANE_W-1:0] lane;
  logic [DATA_W-1:0] buf_rd;
  vec_t              buf_vec;
  vec_t              load_vec;
  logic              in_burst;

  assign in_burst = (state_q == BURST);
  // Lane 0 is presented during the two setup cycles so the store beat is never stale.
  assign lane     = (cnt_q < CNT_W'(DATA_OFS)) ? '0 : LANE_W'(cnt_q - CNT_W'(DATA_OFS));
  assign buf_wr   = in_burst && !we_q && (cnt_q >= CNT_W'(DATA_OFS));

  // The final lane arrives on the same edge that leaves BURST, so splice it in directly.
  always_comb begin
    load_vec = buf_vec;
    load_vec[VEC_W-1 -: DATA_W] = mem_rdata;
  end

  // Next-state, window counter and request latching.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    resp_rdata_d = resp_rdata_q;
    buf_clr      = 1'b0;
    buf_ld       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = BURST;
          cnt_d   = '0;
          we_d    = req_we;
          addr_d  = req_addr;
          buf_ld  = req_we;
          buf_clr = !req_we;
        end
      end
      BURST: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BURST_CYC - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          if (!we_q) resp_rdata_d = load_vec;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  vec_lane_buffer u_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (buf_clr),
    .ld_en   (buf_ld),
    .ld_vec  (req_wdata),
    .wr_en   (buf_wr),
    .wr_lane (lane),
    .wr_data (mem_rdata),
    .rd_lane (lane),
    .rd_data (buf_rd),
    .vec     (buf_vec)
  );

  assign req_ready        = (state_q == IDLE);
  assign busy             = (state_q != IDLE);
  assign resp_valid       = (state_q == DONE);
  assign resp_rdata       = resp_rdata_q;
  assign mem_read_enable  = in_burst && !we_q;
  assign mem_write_enable = in_burst && we_q;
  assign mem_address      = addr_q;
  assign mem_wdata        = (in_burst && we_q) ? buf_rd : '0;

endmodule

// File: tb/tb_vec_mem_burst_ctrl.sv
module tb_vec_mem_burst_ctrl;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [18:0]   req_addr = '0;
  logic [127:0]  req_wdata = '0;
  logic          resp_valid;
  logic [127:0]  resp_rdata;
  logic          busy;
  logic          mem_read_enable;
  logic          mem_write_enable;
  logic [18:0]   mem_address;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int both_hi = 0;

  // Memory model: synchronous read, lane k byte = rd_base + k, valid at window cycle k+2.
  logic [7:0] rd_base = 8'h00;
  logic [4:0] rd_cnt  = 5'd0;
  always @(posedge clk) rd_cnt <= mem_read_enable ? rd_cnt + 5'd1 : 5'd0;
  assign mem_rdata = rd_base + {3'b000, rd_cnt} - 8'd2;

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_read_enable && mem_write_enable) both_hi++;

  vec_mem_burst_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_we           (req_we),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .busy             (busy),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata)
  );

  typedef struct {
    logic         we;
    logic [18:0]  addr;
    logic [127:0] wdata;
    logic [7:0]   rbase;
    logic [127:0] exp_rdata;
  } txn_t;

  txn_t tbl [5];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full request: accept, 18 window cycles, DONE, back to IDLE.
  task automatic run_txn(input txn_t t);
    logic [7:0] beat;
    int         lane;
    req_we    = t.we;
    req_addr  = t.addr;
    req_wdata = t.wdata;
    rd_base   = t.rbase;
    req_valid = 1'b1;
    @(negedge clk);
    chk("ready_before_accept", {159'b0, req_ready}, 160'd1);
    step();
    req_valid = 1'b0;
    req_addr  = ~t.addr;
    req_wdata = ~t.wdata;
    req_we    = ~t.we;
    for (int c = 0; c < 18; c++) begin
      lane = (c < 2) ? 0 : c - 2;
      beat = t.we ? t.wdata[lane*8 +: 8] : 8'h00;
      @(negedge clk);
      chk($sformatf("burst_c%0d", c),
          {128'b0, mem_read_enable, mem_write_enable, busy, req_ready, resp_valid, mem_address, beat},
          {128'b0, !t.we, t.we, 1'b1, 1'b0, 1'b0, t.addr, mem_wdata});
      step();
    end
    @(negedge clk);
    chk("done_flags", {155'b0, resp_valid, busy, req_ready, mem_read_enable, mem_write_enable},
        {155'b0, 5'b11000});
    chk("done_rdata", {32'b0, resp_rdata}, {32'b0, t.exp_rdata});
    step();
    @(negedge clk);
    chk("idle_after_done", {157'b0, resp_valid, busy, req_ready}, {157'b0, 3'b001});
    step();
  endtask

  initial begin
    tbl[0] = '{we: 1'b0, addr: 19'h00100, wdata: 128'h0, rbase: 8'h10,
               exp_rdata: 128'h1F1E1D1C1B1A19181716151413121110};
    tbl[1] = '{we: 1'b1, addr: 19'h7FFF8, wdata: 128'h0F0E0D0C0B0A09080706050403020100, rbase: 8'h00,
               exp_rdata: 128'h1F1E1D1C1B1A19181716151413121110};
    tbl[2] = '{we: 1'b0, addr: 19'h12345, wdata: 128'h0, rbase: 8'hA0,
               exp_rdata: 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0};
    tbl[3] = '{we: 1'b1, addr: 19'h00000, wdata: 128'hDEADBEEF0123456789ABCDEFFEDCBA98, rbase: 8'h00,
               exp_rdata: 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0};
    tbl[4] = '{we: 1'b0, addr: 19'h7FFFF, wdata: 128'h0, rbase: 8'hF8,
               exp_rdata: 128'h0706050403020100FFFEFDFCFBFAF9F8};

    // Reset state
    step(); step();
    @(negedge clk);
    chk("reset_state",
        {resp_rdata, req_ready, busy, resp_valid, mem_read_enable, mem_write_enable, mem_address, mem_wdata},
        {128'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 19'h0, 8'h0});
    step();
    rst = 1'b0;
    step();

    // Idle with no request for 100 cycles
    begin
      int bad = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (busy || mem_read_enable || mem_write_enable || resp_valid || !req_ready) bad++;
        step();
      end
      chk("idle_100_quiet", {128'b0, 32'(bad)}, 160'd0);
    end

    for (int i = 0; i < 5; i++) run_txn(tbl[i]);

    // Back-to-back load then store with req_valid held and req_addr wandering
    begin
      int acc [2];
      int n_acc = 0, cyc_resp = -1, cyc_wen = -1, addr_bad = 0, keep_bad = 0, n_resp = 0;
      logic [127:0] ld_exp = 128'h4F4E4D4C4B4A49484746454443424140;
      req_we    = 1'b0;
      req_addr  = 19'h00200;
      req_wdata = 128'h0;
      rd_base   = 8'h40;
      req_valid = 1'b1;
      for (int cyc = 0; cyc < 42; cyc++) begin
        @(negedge clk);
        if (req_valid && req_ready && n_acc < 2) begin
          acc[n_acc] = cyc;
          n_acc++;
        end
        if (n_acc == 1 && busy && !resp_valid && mem_address !== 19'h00200) addr_bad++;
        if (resp_valid) begin
          n_resp++;
          if (cyc_resp < 0) cyc_resp = cyc;
          if (resp_rdata !== ld_exp) keep_bad++;
        end
        if (mem_write_enable) begin
          if (cyc_wen < 0) cyc_wen = cyc;
          if (resp_rdata !== ld_exp) keep_bad++;
          if (mem_address !== 19'h3000A) addr_bad++;
        end
        if (n_acc == 1 && busy && !resp_valid && req_ready) addr_bad++;
        step();
        if (n_acc == 1 && cyc_resp < 0) req_addr = 19'(cyc * 7 + 1);
        if (cyc == cyc_resp) begin
          req_we    = 1'b1;
          req_addr  = 19'h3000A;
          req_wdata = 128'h55;
        end
        if (n_acc == 2) req_valid = 1'b0;
      end
      chk("b2b_two_accepts", {128'b0, 32'(n_acc)}, 160'd2);
      if (n_acc == 2) chk("b2b_accept_spacing", {128'b0, 32'(acc[1] - acc[0])}, 160'd20);
      chk("b2b_wen_after_resp", {128'b0, 32'(cyc_wen - cyc_resp)}, 160'd2);
      chk("b2b_addr_held", {128'b0, 32'(addr_bad)}, 160'd0);
      chk("b2b_rdata_kept", {128'b0, 32'(keep_bad)}, 160'd0);
      chk("b2b_two_resps", {128'b0, 32'(n_resp)}, 160'd2);
    end

    // Reset in the middle of a load window
    begin
      int late = 0;
      req_we    = 1'b0;
      req_addr  = 19'h00ABC;
      rd_base   = 8'h55;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      for (int c = 0; c < 9; c++) step();
      @(negedge clk);
      chk("pre_reset_busy", {158'b0, busy, mem_read_enable}, {158'b0, 2'b11});
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("mid_reset_state",
          {resp_rdata, req_ready, busy, resp_valid, mem_read_enable, mem_write_enable, 19'b0, 8'b0},
          {128'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 19'b0, 8'b0});
      step();
      for (int i = 0; i < 25; i++) begin
        @(negedge clk);
        if (resp_valid || mem_read_enable || busy) late++;
        step();
      end
      chk("no_resp_after_reset", {128'b0, 32'(late)}, 160'd0);
    end

    chk("never_both_enables", {128'b0, 32'(both_hi)}, 160'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
